// File: rtl/tlc_phase_ctrl_if.sv
// Request/lamp bundle between the TLC phase sequencer (master) and its surroundings (slave).
interface tlc_phase_ctrl_if;
    logic       TICK;
    logic       HS_REQ;
    logic       FS_REQ;
    logic [2:0] H_LAMP;
    logic [2:0] F_LAMP;
    logic       HLEFT;
    logic       FLEFT;
    logic [2:0] PHASE;

    modport master (
        input  TICK, HS_REQ, FS_REQ,
        output H_LAMP, F_LAMP, HLEFT, FLEFT, PHASE
    );

    modport slave (
        output TICK, HS_REQ, FS_REQ,
        input  H_LAMP, F_LAMP, HLEFT, FLEFT, PHASE
    );
endinterface

// File: rtl/tlc_phase_ctrl.sv
// TLC phase sequencer: Moore FSM with a TICK-driven phase timer.
// Optional night flashing mode is compiled in with TLC_NIGHT_FLASH_EN.
module tlc_phase_ctrl #(
    parameter int unsigned T_HG_MIN = 8,
    parameter int unsigned T_LEFT   = 3,
    parameter int unsigned T_Y      = 2,
    parameter int unsigned T_FG     = 5,
    parameter int unsigned TW       = 5
) (
    input  logic MCLK,
    input  logic nRST,
`ifdef TLC_NIGHT_FLASH_EN
    input  logic NIGHT,
`endif
    tlc_phase_ctrl_if.master bus
);

`ifdef TLC_NIGHT_FLASH_EN
    typedef enum logic [2:0] {
        StHg    = 3'd0,
        StHl    = 3'd1,
        StHy    = 3'd2,
        StFg    = 3'd3,
        StFl    = 3'd4,
        StFy    = 3'd5,
        StFlash = 3'd6
    } state_e;
`else
    typedef enum logic [2:0] {
        StHg = 3'd0,
        StHl = 3'd1,
        StHy = 3'd2,
        StFg = 3'd3,
        StFl = 3'd4,
        StFy = 3'd5
    } state_e;
`endif

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          exp_hg, exp_left, exp_y, exp_fg;

    assign exp_hg   = bus.TICK && (cnt_q == TW'(T_HG_MIN - 1));
    assign exp_left = bus.TICK && (cnt_q == TW'(T_LEFT - 1));
    assign exp_y    = bus.TICK && (cnt_q == TW'(T_Y - 1));
    assign exp_fg   = bus.TICK && (cnt_q == TW'(T_FG - 1));

`ifdef TLC_NIGHT_FLASH_EN
    logic blink_q, blink_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = bus.TICK ? cnt_q + TW'(1) : cnt_q;
        unique case (state_q)
            StHg: begin
                if (exp_hg) begin
                    if (bus.HS_REQ) begin
                        state_d = StHl;
                    end else if (bus.FS_REQ) begin
                        state_d = StHy;
                    end else begin
                        // Minimum green served: park at the last count so every TICK re-decides.
                        cnt_d = cnt_q;
                    end
                end
            end
            StHl: if (exp_left) state_d = bus.FS_REQ ? StHy : StHg;
            StHy: if (exp_y)    state_d = StFg;
            StFg: if (exp_fg)   state_d = bus.FS_REQ ? StFl : StFy;
            StFl: if (exp_left) state_d = StFy;
            StFy: if (exp_y)    state_d = StHg;
`ifdef TLC_NIGHT_FLASH_EN
            StFlash: if (!NIGHT) state_d = StFy;
`endif
            default: state_d = StHg;
        endcase

`ifdef TLC_NIGHT_FLASH_EN
        if (NIGHT) begin
            state_d = StFlash;
            cnt_d   = '0;
        end
`endif

        if (state_d != state_q) begin
            cnt_d = '0;
        end

`ifdef TLC_NIGHT_FLASH_EN
        // Blink restarts dark on every entry into FLASH.
        blink_d = 1'b0;
        if (state_q == StFlash && state_d == StFlash) begin
            blink_d = blink_q ^ bus.TICK;
        end
`endif
    end

    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            state_q <= StHg;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TLC_NIGHT_FLASH_EN
    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end
`endif

    always_comb begin
        bus.H_LAMP = 3'b100;
        bus.F_LAMP = 3'b100;
        bus.HLEFT  = 1'b0;
        bus.FLEFT  = 1'b0;
        unique case (state_q)
            StHg: bus.H_LAMP = 3'b001;
            StHl: begin
                bus.H_LAMP = 3'b001;
                bus.HLEFT  = 1'b1;
            end
            StHy: bus.H_LAMP = 3'b010;
            StFg: bus.F_LAMP = 3'b001;
            StFl: begin
                bus.F_LAMP = 3'b001;
                bus.FLEFT  = 1'b1;
            end
            StFy: bus.F_LAMP = 3'b010;
`ifdef TLC_NIGHT_FLASH_EN
            StFlash: begin
                bus.H_LAMP = {1'b0, blink_q, 1'b0};
                bus.F_LAMP = {blink_q, 2'b00};
            end
`endif
            default: ;
        endcase
        bus.PHASE = state_q;
    end

endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// Directed self-checking bench for tlc_phase_ctrl; models the upstream request latch.
module tb_tlc_phase_ctrl;
    logic MCLK = 1'b0;
    logic nRST = 1'b0;
`ifdef TLC_NIGHT_FLASH_EN
    logic NIGHT = 1'b0;
`endif
    int checks = 0;
    int errors = 0;

    tlc_phase_ctrl_if bus ();

    tlc_phase_ctrl dut (
        .MCLK (MCLK),
        .nRST (nRST),
`ifdef TLC_NIGHT_FLASH_EN
        .NIGHT(NIGHT),
`endif
        .bus  (bus.master)
    );

    always #5 MCLK = ~MCLK;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One MCLK cycle; the latch clears a request one cycle after its arrow lights.
    task automatic step(input logic tk);
        bus.TICK = tk;
        @(posedge MCLK);
        #1;
        bus.TICK = 1'b0;
        if (bus.HLEFT) bus.HS_REQ = 1'b0;
        if (bus.FLEFT) bus.FS_REQ = 1'b0;
        check_eq("excl", 8'((bus.H_LAMP[1] | bus.H_LAMP[0]) & (bus.F_LAMP[1] | bus.F_LAMP[0])),
                 8'd0);
    endtask

    task automatic tick();
        step(1'b1);
        step(1'b0);
    endtask

    function automatic logic [2:0] h_exp(input int ph);
        case (ph)
            0, 1:    return 3'b001;
            2:       return 3'b010;
            3, 4, 5: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] f_exp(input int ph);
        case (ph)
            0, 1, 2: return 3'b100;
            3, 4:    return 3'b001;
            5:       return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Phase must hold for n-1 TICKs and still be present before the n-th.
    task automatic expect_phase(input int ph, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_ph"}, 8'(bus.PHASE), 8'(ph));
            check_eq({tag, "_h"}, 8'(bus.H_LAMP), 8'(h_exp(ph)));
            check_eq({tag, "_f"}, 8'(bus.F_LAMP), 8'(f_exp(ph)));
            check_eq({tag, "_hl"}, 8'(bus.HLEFT), 8'(ph == 1));
            check_eq({tag, "_fl"}, 8'(bus.FLEFT), 8'(ph == 4));
            tick();
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        step(1'b0);
        nRST = 1'b1;
    endtask

    initial begin
        bus.TICK   = 1'b0;
        bus.HS_REQ = 1'b0;
        bus.FS_REQ = 1'b0;
        step(1'b0);
        step(1'b0);
        nRST = 1'b1;

        check_eq("rst_ph", 8'(bus.PHASE), 8'd0);
        check_eq("rst_h", 8'(bus.H_LAMP), 8'b001);
        check_eq("rst_f", 8'(bus.F_LAMP), 8'b100);
        check_eq("rst_hl", 8'(bus.HLEFT), 8'd0);
        check_eq("rst_fl", 8'(bus.FLEFT), 8'd0);

        expect_phase(0, 30, "idle");
        bus.HS_REQ = 1'b1;
        tick();
        check_eq("reeval_hl", 8'(bus.PHASE), 8'd1);

        do_reset();
        bus.FS_REQ = 1'b1;
        expect_phase(0, 8, "fs_hg");
        expect_phase(2, 2, "fs_hy");
        expect_phase(3, 5, "fs_fg");
        expect_phase(4, 3, "fs_fl");
        expect_phase(5, 2, "fs_fy");
        expect_phase(0, 10, "fs_back");

        do_reset();
        bus.HS_REQ = 1'b1;
        expect_phase(0, 8, "hs_hg");
        expect_phase(1, 3, "hs_hl");
        expect_phase(0, 2, "hs_back");

        do_reset();
        bus.HS_REQ = 1'b1;
        bus.FS_REQ = 1'b1;
        expect_phase(0, 8, "both_hg");
        expect_phase(1, 3, "both_hl");
        expect_phase(2, 2, "both_hy");
        expect_phase(3, 5, "both_fg");
        expect_phase(4, 3, "both_fl");
        expect_phase(5, 2, "both_fy");
        expect_phase(0, 1, "both_hg2");

        do_reset();
        bus.FS_REQ = 1'b1;
        expect_phase(0, 8, "r_hg");
        expect_phase(2, 2, "r_hy");
        tick();
        tick();
        tick();
        check_eq("r_fg3", 8'(bus.PHASE), 8'd3);
        nRST = 1'b0;
        step(1'b0);
        nRST = 1'b1;
        check_eq("r_mid_ph", 8'(bus.PHASE), 8'd0);
        check_eq("r_mid_h", 8'(bus.H_LAMP), 8'b001);
        check_eq("r_mid_f", 8'(bus.F_LAMP), 8'b100);
        expect_phase(0, 8, "r_cnt0");
        check_eq("r_to_hy", 8'(bus.PHASE), 8'd2);
        nRST = 1'b0;
        step(1'b1);
        nRST = 1'b1;
        check_eq("r_tick_ph", 8'(bus.PHASE), 8'd0);
        expect_phase(0, 8, "r_tick_cnt");
        check_eq("r_tick_hy", 8'(bus.PHASE), 8'd2);
        nRST = 1'b0;
        step(1'b0);
        step(1'b0);
        nRST = 1'b1;
        check_eq("r_hold_ph", 8'(bus.PHASE), 8'd0);

`ifdef TLC_NIGHT_FLASH_EN
        do_reset();
        bus.FS_REQ = 1'b0;
        bus.HS_REQ = 1'b1;
        expect_phase(0, 8, "n_hg");
        tick();
        check_eq("n_in_hl", 8'(bus.PHASE), 8'd1);
        NIGHT = 1'b1;
        step(1'b0);
        check_eq("n_ph", 8'(bus.PHASE), 8'd6);
        check_eq("n_hl", 8'(bus.HLEFT), 8'd0);
        check_eq("n_h0", 8'(bus.H_LAMP), 8'b000);
        check_eq("n_f0", 8'(bus.F_LAMP), 8'b000);
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            check_eq("n_blink_h", 8'(bus.H_LAMP), (i % 2 == 0) ? 8'b010 : 8'b000);
            check_eq("n_blink_f", 8'(bus.F_LAMP), (i % 2 == 0) ? 8'b100 : 8'b000);
            step(1'b0);
        end
        NIGHT = 1'b0;
        step(1'b0);
        expect_phase(5, 2, "n_fy");
        check_eq("n_hg_end", 8'(bus.PHASE), 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
